// File: rtl/cdc_sync_multi_fout.sv
// Multi-channel slow-to-fast input conditioner: flop synchroniser, stability
// filter, per-channel edge pulse and a sticky, software-clearable event flag.
module cdc_sync_multi_fout #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic [CH-1:0]     async_in,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     evt_clr,
  output logic [CH-1:0]     level_out,
  output logic [CH-1:0]     pulse_out,
  output logic [CH-1:0]     event_flag
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Per-channel edge selection: 00 none, 01 rise, 10 fall, 11 either.
  function automatic logic edge_sel(input logic [1:0] m, input logic cur,
                                    input logic prev);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (m)
      2'b01:   edge_sel = rise;
      2'b10:   edge_sel = fall;
      2'b11:   edge_sel = rise | fall;
      default: edge_sel = 1'b0;
    endcase
  endfunction

  logic [CH-1:0]    sync_p0 [SYNC_STAGES];
  logic [CH-1:0]    s_p0;
  logic [CNT_W-1:0] cnt_p1  [CH];
  logic [CH-1:0]    lvl_d_p2;
  logic [CH-1:0]    sel_p2;

  // Stage 0: synchroniser chain, every channel captured in parallel.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_p0[j] <= '0;
    end else begin
      sync_p0[0] <= async_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_p0[j] <= sync_p0[j-1];
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage 1: stability filter; level follows only after FILTER_LEN
  // consecutive mismatching samples, any agreement restarts the count.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      level_out <= '0;
      for (int i = 0; i < CH; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (s_p0[i] == level_out[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] == CNT_LAST) begin
          level_out[i] <= s_p0[i];
          cnt_p1[i]    <= '0;
        end else begin
          cnt_p1[i] <= cnt_p1[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    sel_p2 = '0;
    for (int i = 0; i < CH; i++)
      sel_p2[i] = edge_sel(mode[2*i +: 2], level_out[i], lvl_d_p2[i]);
  end

  // Stage 2: edge pulse and sticky flag; a new edge outranks a clear.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      lvl_d_p2   <= '0;
      pulse_out  <= '0;
      event_flag <= '0;
    end else begin
      lvl_d_p2   <= level_out;
      pulse_out  <= sel_p2;
      event_flag <= sel_p2 | (event_flag & ~evt_clr);
    end
  end

endmodule

// File: doc/cdc_sync_multi_fout.md
Name: cdc_sync_multi_fout

Overview:
Parametrised multi-channel input conditioner that lives in the fast (destination) clock domain. It takes CH asynchronous single-bit signals and passes each through a SYNC_STAGES flop synchroniser and a FILTER_LEN-cycle stability filter. Each channel produces a clean level output, a one-cycle pulse chosen by a per-channel edge mode, and a sticky event flag that software can clear. It generalises the 8-bit slow-to-fast synchroniser with configurable depth, debounce, edge detection and event capture.

Parameters:
CH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
FILTER_LEN, 4, consecutive stable cycles required before the level output changes (>=1; 1 = no filtering beyond one register)

Ports:
fast_clk  input  1  destination clock; every flop in the block is on this clock
reset  input  1  synchronous, active-high reset
async_in  input  CH  asynchronous per-channel inputs
mode  input  2*CH  per-channel edge mode, bits [2i+1:2i]: 00 level only, 01 rise, 10 fall, 11 any edge; quasi-static
evt_clr  input  CH  per-channel clear for event_flag, sampled on fast_clk
level_out  output  CH  synchronised and filtered level
pulse_out  output  CH  one-cycle edge pulse per mode
event_flag  output  CH  sticky edge-detected flag

Behaviour:
- Reset: on a fast_clk edge with reset=1, all synchroniser flops, filter counters, level_out, pulse_out and event_flag go to 0. Reset has priority over every other input.
- Synchroniser: async_in[i] is shifted through SYNC_STAGES flops. s[i] is the last stage.
- Filter, per channel:
  - Counter width is clog2(FILTER_LEN+1).
  - If s[i]==level_out[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches FILTER_LEN-1 while s[i] still differs, level_out[i] takes s[i] on that edge and the counter clears.
  - A mismatch lasting fewer than FILTER_LEN cycles leaves level_out unchanged.
- Level latency: a change sampled at edge k (first sync flop captures it) appears on level_out at edge k+SYNC_STAGES+FILTER_LEN-1. Sim-exact; real hardware adds up to one cycle of metastability uncertainty.
- Edge detect: registered copy lvl_d of level_out.
  - rise = level_out & ~lvl_d
  - fall = ~level_out & lvl_d
  - sel selects from these per mode: 00 → 0, 01 → rise, 10 → fall, 11 → rise|fall.
- pulse_out[i] is registered sel[i]. It is high for exactly one cycle, one cycle after the level_out transition. Total latency from sampled input change is SYNC_STAGES+FILTER_LEN cycles.
- Consecutive filtered transitions are at least FILTER_LEN cycles apart, so pulses are never merged when FILTER_LEN>=2.
- event_flag[i] next-state:
  - set when sel[i]=1 (same edge pulse_out asserts)
  - else cleared when evt_clr[i]=1
  - else holds
  - Simultaneous set and clear: set wins.
- mode change: takes effect on the next edge-detect evaluation. No pulse is generated by the mode change itself.
- Reset mid-operation: state returns to 0. If async_in is high at reset release, it is treated as a fresh 0→1 transition, so a rise pulse occurs after the full latency.
- Channels are fully independent. Activity on one channel never affects another.

Test Plan (CH=8, SYNC_STAGES=2, FILTER_LEN=4; edge 0 = first sampling of change):
1. Hold reset=1 for 4 cycles with async_in=8'hFF → level_out, pulse_out and event_flag all 8'h00 throughout reset.
2. mode ch1=01, async_in 8'h00→8'h02 held → level_out=8'h02 at edge 5, pulse_out[1]=1 only in the cycle after edge 6, event_flag[1]=1 from edge 6 and held.
3. mode ch2=11, async_in[2] high for 3 cycles then low → level_out[2], pulse_out[2] and event_flag[2] stay 0.
4. All modes=11, async_in sequence 8'h02 (held 10 cycles) → 8'h0E (10) → 8'h00 (10) → 8'h02 → each level_out change follows its input by the fixed latency. Pulses occur on bit1 (rise), bits 2,3 (rise), bits 1,2,3 (fall), then bit1 (rise). event_flag=8'h0E.
5. With event_flag[1]=1: assert evt_clr[1] alone → flag 0 next cycle. Assert evt_clr[1] on the same edge a new pulse sets it → flag remains 1.
6. async_in[0] held high with mode ch0=01; pulse reset for 1 cycle mid-operation → all outputs 0 on the next edge. After release, level_out[0] rises at edge 5 and pulse_out[0] fires one cycle after edge 6.
